// File: rtl/msk_pkg.sv
// msk_pkg: shared FSM type, phase-width helper and sin/cos LUT entry generator
// for the MSK transmit modulator.
package msk_pkg;

    typedef enum logic {IDLE, RUN} msk_tx_state_t;

    function automatic int msk_pw(input int sps);
        return $clog2(4 * sps);
    endfunction

    // Entry k of a 4*sps-entry quarter-wave-step table, rounded half away from zero.
    function automatic logic signed [31:0] msk_lut_val(input int k, input int sps, input int amp, input bit is_sin);
        real a;
        int  r;
        a = 6.283185307179586 * real'(k) / real'(4 * sps);
        a = real'(amp) * (is_sin ? $sin(a) : $cos(a));
        r = $rtoi((a < 0.0 ? -a : a) + 0.5);
        return a < 0.0 ? -r : r;
    endfunction

endpackage

// File: rtl/msk_tx_modulator_if.sv
// msk_tx_modulator_if: bit input handshake, control and I/Q sample output bundle.
interface msk_tx_modulator_if #(parameter int DW = 16) ();
    logic                 enable;
    logic                 ce;
    logic                 bit_in;
    logic                 bit_valid;
    logic                 bit_ready;
    logic signed [DW-1:0] I_out;
    logic signed [DW-1:0] Q_out;
    logic                 sample_valid;
    logic                 symbol_strobe;
    logic                 underrun;

    modport master (
        output enable, ce, bit_in, bit_valid,
        input  bit_ready, I_out, Q_out, sample_valid, symbol_strobe, underrun
    );

    modport slave (
        input  enable, ce, bit_in, bit_valid,
        output bit_ready, I_out, Q_out, sample_valid, symbol_strobe, underrun
    );
endinterface

// File: rtl/msk_sincos_lut.sv
// msk_sincos_lut: registered phase-to-I/Q lookup; the only pipeline stage of the modulator.
module msk_sincos_lut import msk_pkg::*; #(
    parameter  int SPS = 8,
    parameter  int DW  = 16,
    parameter  int AMP = 2**(DW-1)-1,
    localparam int PW  = msk_pw(SPS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear_i,
    input  logic                 load_i,
    input  logic                 strobe_i,
    input  logic [PW-1:0]        phase_i,
    output logic signed [DW-1:0] i_o,
    output logic signed [DW-1:0] q_o,
    output logic                 valid_o,
    output logic                 strobe_o
);
    logic signed [DW-1:0] cos_tab [4*SPS];
    logic signed [DW-1:0] sin_tab [4*SPS];
    logic signed [DW-1:0] i_q, q_q;
    logic                 valid_q, strobe_q;

    for (genvar k = 0; k < 4*SPS; k++) begin : g_tab
        assign cos_tab[k] = DW'(msk_lut_val(k, SPS, AMP, 1'b0));
        assign sin_tab[k] = DW'(msk_lut_val(k, SPS, AMP, 1'b1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_q      <= '0;
            q_q      <= '0;
            valid_q  <= 1'b0;
            strobe_q <= 1'b0;
        end else begin
            valid_q  <= load_i;
            strobe_q <= load_i && strobe_i;
            i_q      <= clear_i ? '0 : load_i ? cos_tab[phase_i] : i_q;
            q_q      <= clear_i ? '0 : load_i ? sin_tab[phase_i] : q_q;
        end
    end

    assign i_o      = i_q;
    assign q_o      = q_q;
    assign valid_o  = valid_q;
    assign strobe_o = strobe_q;
endmodule

// File: rtl/msk_tx_modulator.sv
// msk_tx_modulator: bit FIFO, phase accumulator and symbol FSM driving a sin/cos LUT
// to produce SPS continuous-phase MSK I/Q samples per input bit.
module msk_tx_modulator import msk_pkg::*; #(
    parameter int SPS        = 8,
    parameter int DW         = 16,
    parameter int AMP        = 2**(DW-1)-1,
    parameter int FIFO_DEPTH = 2
) (
    input logic                clk,
    input logic                reset_n,
    msk_tx_modulator_if.slave  bus
);
    localparam int PW = msk_pw(SPS);
    localparam int CW = $clog2(SPS);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int NW = $clog2(FIFO_DEPTH + 1);

    msk_tx_state_t state_q, state_d;
    logic [PW-1:0] phase_q, phase_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          dir_q, dir_d;
    logic          pend_q, pend_d;
    logic          underrun_q, underrun_d;
    logic [1:0]    rst_sync_q;
    logic          rst_n;
    logic          mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [NW-1:0] count_q;
    logic          empty, full, push, pop;

    // Reset asserts asynchronously but releases on a clock edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rst_sync_q <= '0;
        else          rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n = rst_sync_q[1];

    assign full          = count_q == NW'(FIFO_DEPTH);
    assign empty         = count_q == '0;
    assign bus.bit_ready = rst_n && !full;
    assign push          = bus.bit_valid && bus.bit_ready;

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        cnt_d      = cnt_q;
        dir_d      = dir_q;
        pend_d     = pend_q;
        underrun_d = 1'b0;
        pop        = 1'b0;
        if (state_q == IDLE) begin
            phase_d = '0;
            cnt_d   = '0;
            if (bus.ce && bus.enable && !empty) begin
                pop     = 1'b1;
                dir_d   = mem_q[rd_q];
                pend_d  = 1'b1;
                state_d = RUN;
            end
        end else if (bus.ce) begin
            phase_d = dir_q ? phase_q + PW'(1) : phase_q - PW'(1);
            cnt_d   = cnt_q + CW'(1);
            pend_d  = 1'b0;
            if (cnt_q == CW'(SPS-1)) begin
                if (bus.enable && !empty) begin
                    pop    = 1'b1;
                    dir_d  = mem_q[rd_q];
                    pend_d = 1'b1;
                end else begin
                    state_d    = IDLE;
                    underrun_d = bus.enable;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            phase_q    <= '0;
            cnt_q      <= '0;
            dir_q      <= 1'b0;
            pend_q     <= 1'b0;
            underrun_q <= 1'b0;
            wr_q       <= '0;
            rd_q       <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            cnt_q      <= cnt_d;
            dir_q      <= dir_d;
            pend_q     <= pend_d;
            underrun_q <= underrun_d;
            wr_q       <= push ? wr_q + AW'(1) : wr_q;
            rd_q       <= pop ? rd_q + AW'(1) : rd_q;
            count_q    <= count_q + NW'(push) - NW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= bus.bit_in;
    end

    msk_sincos_lut #(.SPS(SPS), .DW(DW), .AMP(AMP)) u_lut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear_i  (state_q == IDLE),
        .load_i   (state_q == RUN && bus.ce),
        .strobe_i (pend_q),
        .phase_i  (phase_d),
        .i_o      (bus.I_out),
        .q_o      (bus.Q_out),
        .valid_o  (bus.sample_valid),
        .strobe_o (bus.symbol_strobe)
    );

    assign bus.underrun = underrun_q;
endmodule
